// File: rtl/irr_param_if.sv
// Bus bundle for the interrupt request register: raw request lines, per-channel
// configuration, acknowledge/clear strobes and the registered status outputs.
interface irr_param_if #(
    parameter int N = 8
);
    localparam int IW = $clog2(N);

    logic [N-1:0]  ir_in;
    logic [N-1:0]  ltim;
    logic [N-1:0]  imr;
    logic [IW-1:0] pri_base;
    logic          ack_valid;
    logic [IW-1:0] ack_id;
    logic          lost_clr;
    logic [N-1:0]  irr;
    logic          int_req;
    logic [IW-1:0] int_id;
    logic [N-1:0]  lost;

    modport master (
        output ir_in, ltim, imr, pri_base, ack_valid, ack_id, lost_clr,
        input  irr, int_req, int_id, lost
    );

    modport slave (
        input  ir_in, ltim, imr, pri_base, ack_valid, ack_id, lost_clr,
        output irr, int_req, int_id, lost
    );
endinterface

// File: rtl/irr_param.sv
// Parameterised interrupt request register: per-channel synchroniser, edge/level
// capture with acknowledge, sticky lost flags and a rotating-priority arbiter.
module irr_param #(
    parameter int N           = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    irr_param_if.slave  bus
);
    localparam int IW = $clog2(N);
    // The chain plus the edge-detect flop must refill before edges are trusted.
    localparam logic [2:0] FILL_DONE = 3'(SYNC_STAGES + 1);

    logic [N-1:0]  sync_q [SYNC_STAGES];
    logic [N-1:0]  p_q;
    logic [N-1:0]  irr_q;
    logic [N-1:0]  lost_q;
    logic          int_req_q;
    logic [IW-1:0] int_id_q;
    logic [2:0]    fill_cnt;

    logic [N-1:0]  s;
    logic          refilling;
    logic [N-1:0]  edge_det;
    logic [N-1:0]  ack_hit;
    logic [N-1:0]  irr_n;
    logic [N-1:0]  lost_n;
    logic [N-1:0]  masked;
    logic          win_found;
    logic [IW-1:0] win_id;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        s         = sync_q[SYNC_STAGES-1];
        refilling = (fill_cnt != FILL_DONE);
        ack_hit   = '0;
        for (int i = 0; i < N; i++) begin
            ack_hit[i] = bus.ack_valid && (int'(bus.ack_id) == i);
        end
        edge_det = ~bus.ltim & s & ~p_q & {N{~refilling}};

        irr_n = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.ltim[i]) begin
                irr_n[i] = s[i] & ~ack_hit[i];
            end else begin
                // A fresh edge beats a same-clock acknowledge.
                irr_n[i] = edge_det[i] | (irr_q[i] & ~ack_hit[i]);
            end
        end
        lost_n = (edge_det & irr_q & ~ack_hit) | (lost_q & ~{N{bus.lost_clr}});
    end

    // Rotating search: first unmasked pending channel at or after pri_base.
    always_comb begin
        masked    = irr_q & ~bus.imr;
        win_found = 1'b0;
        win_id    = '0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (int'(bus.pri_base) + k) % N;
            if (!win_found && masked[idx]) begin
                win_found = 1'b1;
                win_id    = IW'(idx);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, which keeps the synchroniser a true shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            p_q       <= '0;
            irr_q     <= '0;
            lost_q    <= '0;
            int_req_q <= 1'b0;
            int_id_q  <= '0;
            fill_cnt  <= '0;
        end else begin
            sync_q[0] <= bus.ir_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            // p tracks s in both trigger modes so a mode switch never fakes an edge.
            p_q       <= s;
            irr_q     <= irr_n;
            lost_q    <= lost_n;
            int_req_q <= win_found;
            int_id_q  <= win_id;
            if (refilling) begin
                fill_cnt <= fill_cnt + 3'd1;
            end
        end
    end

    assign bus.irr     = irr_q;
    assign bus.lost    = lost_q;
    assign bus.int_req = int_req_q;
    assign bus.int_id  = int_id_q;
endmodule

// File: tb/tb_irr_param.sv
// Directed scoreboard bench for irr_param (N=8, SYNC_STAGES=2): stimulus pushes
// cycle-tagged expectations, a negedge monitor pops and compares them.
module tb_irr_param;
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    irr_param_if #(.N(8)) bus ();

    irr_param #(.N(8), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string      name;
        int         cyc;
        logic [7:0] irr_m;
        logic [7:0] irr_v;
        logic [7:0] lost_m;
        logic [7:0] lost_v;
        bit         chk_int;
        logic       req;
        logic [2:0] id;
    } exp_t;

    exp_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Expectation sampled at the negedge after `dly` further rising edges.
    task automatic sb_push(input string name, input int dly,
                           input logic [7:0] irr_m, input logic [7:0] irr_v,
                           input logic [7:0] lost_m, input logic [7:0] lost_v,
                           input bit chk_int, input logic req, input logic [2:0] id);
        exp_t e;
        e.name = name;   e.cyc = cyc + dly;
        e.irr_m = irr_m; e.irr_v = irr_v;
        e.lost_m = lost_m; e.lost_v = lost_v;
        e.chk_int = chk_int; e.req = req; e.id = id;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].cyc <= cyc) begin
                e = sb_q[i];
                if (e.irr_m != 8'h00)
                    check({e.name, ".irr"}, 32'(bus.irr & e.irr_m), 32'(e.irr_v));
                if (e.lost_m != 8'h00)
                    check({e.name, ".lost"}, 32'(bus.lost & e.lost_m), 32'(e.lost_v));
                if (e.chk_int) begin
                    check({e.name, ".int_req"}, 32'(bus.int_req), 32'(e.req));
                    check({e.name, ".int_id"}, 32'(bus.int_id), 32'(e.id));
                end
                sb_q.delete(i);
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        bus.ir_in     = '0;
        bus.ltim      = '0;
        bus.imr       = '0;
        bus.pri_base  = '0;
        bus.ack_valid = 1'b0;
        bus.ack_id    = '0;
        bus.lost_clr  = 1'b0;
        tick(3);
        sb_push("reset", 0, 8'hFF, 8'h00, 8'hFF, 8'h00, 1, 1'b0, 3'd0);
        reset = 1'b0;
        tick(5);

        // Edge capture latency, hold after input drops, acknowledge.
        bus.ir_in = 8'h08;
        sb_push("t1_irr_set", 3, 8'hFF, 8'h08, 8'hFF, 8'h00, 1, 1'b0, 3'd0);
        sb_push("t1_int",     4, 8'hFF, 8'h08, 8'hFF, 8'h00, 1, 1'b1, 3'd3);
        tick(4);
        bus.ir_in = 8'h00;
        sb_push("t1_hold", 4, 8'hFF, 8'h08, 8'hFF, 8'h00, 1, 1'b1, 3'd3);
        tick(4);
        bus.ack_valid = 1'b1; bus.ack_id = 3'd3;
        sb_push("t1_ack",    1, 8'hFF, 8'h00, 8'hFF, 8'h00, 1, 1'b1, 3'd3);
        sb_push("t1_intclr", 2, 8'hFF, 8'h00, 8'hFF, 8'h00, 1, 1'b0, 3'd0);
        tick(1);
        bus.ack_valid = 1'b0;
        tick(3);

        // Second edge while pending sets lost; lost_clr leaves irr alone.
        bus.ir_in = 8'h20;
        sb_push("t2_first", 3, 8'hFF, 8'h20, 8'hFF, 8'h00, 0, 1'b0, 3'd0);
        tick(1); bus.ir_in = 8'h00; tick(5);
        bus.ir_in = 8'h20;
        sb_push("t2_lost", 3, 8'hFF, 8'h20, 8'hFF, 8'h20, 1, 1'b1, 3'd5);
        tick(1); bus.ir_in = 8'h00; tick(4);
        bus.lost_clr = 1'b1;
        sb_push("t2_clr", 1, 8'hFF, 8'h20, 8'hFF, 8'h00, 1, 1'b1, 3'd5);
        tick(1);
        bus.lost_clr = 1'b0;
        bus.ack_valid = 1'b1; bus.ack_id = 3'd5;
        sb_push("t2_ack", 1, 8'hFF, 8'h00, 8'hFF, 8'h00, 0, 1'b0, 3'd0);
        tick(1); bus.ack_valid = 1'b0; tick(3);

        // Level channel 2: ack drops it for one clock, release clears it.
        bus.ltim = 8'h04;
        bus.ir_in = 8'h04;
        sb_push("t3_set", 3, 8'hFF, 8'h04, 8'hFF, 8'h00, 0, 1'b0, 3'd0);
        tick(4);
        bus.ack_valid = 1'b1; bus.ack_id = 3'd2;
        sb_push("t3_ack_low",  1, 8'hFF, 8'h00, 8'hFF, 8'h00, 0, 1'b0, 3'd0);
        sb_push("t3_reassert", 2, 8'hFF, 8'h04, 8'hFF, 8'h00, 0, 1'b0, 3'd0);
        tick(1); bus.ack_valid = 1'b0; tick(3);
        bus.ir_in = 8'h00;
        sb_push("t3_rel_hi", 2, 8'h04, 8'h04, 8'hFF, 8'h00, 0, 1'b0, 3'd0);
        sb_push("t3_rel_lo", 3, 8'hFF, 8'h00, 8'hFF, 8'h00, 0, 1'b0, 3'd0);
        tick(5);

        // Level-to-edge switch with the line high must not fake an edge.
        bus.ir_in = 8'h04;
        tick(5);
        bus.ltim = 8'h00;
        sb_push("t3_mode_hold", 2, 8'hFF, 8'h04, 8'hFF, 8'h00, 0, 1'b0, 3'd0);
        tick(3);
        bus.ack_valid = 1'b1; bus.ack_id = 3'd2;
        sb_push("t3_edge_ack", 1, 8'hFF, 8'h00, 8'hFF, 8'h00, 0, 1'b0, 3'd0);
        sb_push("t3_no_edge",  3, 8'hFF, 8'h00, 8'hFF, 8'h00, 1, 1'b0, 3'd0);
        tick(1); bus.ack_valid = 1'b0; tick(3);
        bus.ir_in = 8'h00;
        tick(4);

        // Rotating priority and masking over irr=0x81.
        bus.ir_in = 8'h81;
        sb_push("t4_base0", 4, 8'hFF, 8'h81, 8'hFF, 8'h00, 1, 1'b1, 3'd0);
        tick(1); bus.ir_in = 8'h00; tick(4);
        bus.pri_base = 3'd1;
        sb_push("t4_base1", 1, 8'hFF, 8'h81, 8'hFF, 8'h00, 1, 1'b1, 3'd7);
        tick(2);
        bus.imr = 8'h80;
        sb_push("t4_mask7", 1, 8'hFF, 8'h81, 8'hFF, 8'h00, 1, 1'b1, 3'd0);
        tick(2);
        bus.imr = 8'h81;
        sb_push("t4_allmask", 1, 8'hFF, 8'h81, 8'hFF, 8'h00, 1, 1'b0, 3'd0);
        tick(2);
        bus.imr = 8'h00; bus.pri_base = 3'd7;
        sb_push("t4_base7", 1, 8'hFF, 8'h81, 8'hFF, 8'h00, 1, 1'b1, 3'd7);
        tick(2);
        bus.pri_base = 3'd0;
        bus.ack_valid = 1'b1; bus.ack_id = 3'd0;
        tick(1);
        bus.ack_id = 3'd7;
        sb_push("t4_acked", 1, 8'hFF, 8'h00, 8'hFF, 8'h00, 0, 1'b0, 3'd0);
        tick(1); bus.ack_valid = 1'b0; tick(2);

        // Same-clock edge and acknowledge: set wins, no lost.
        bus.ir_in = 8'h10;
        sb_push("t5_set", 3, 8'hFF, 8'h10, 8'hFF, 8'h00, 0, 1'b0, 3'd0);
        tick(1); bus.ir_in = 8'h00; tick(5);
        bus.ir_in = 8'h10;
        tick(1); bus.ir_in = 8'h00; tick(1);
        bus.ack_valid = 1'b1; bus.ack_id = 3'd4;
        sb_push("t5_same_clk", 1, 8'hFF, 8'h10, 8'hFF, 8'h00, 1, 1'b1, 3'd4);
        tick(1); bus.ack_valid = 1'b0; tick(3);

        // Reset with all lines high: everything clears, refill stays silent.
        bus.ir_in = 8'hFF;
        reset = 1'b1;
        tick(2);
        sb_push("t5_reset", 0, 8'hFF, 8'h00, 8'hFF, 8'h00, 1, 1'b0, 3'd0);
        reset = 1'b0;
        sb_push("t5_rel3", 3, 8'hFF, 8'h00, 8'hFF, 8'h00, 1, 1'b0, 3'd0);
        sb_push("t5_rel4", 4, 8'hFF, 8'h00, 8'hFF, 8'h00, 1, 1'b0, 3'd0);
        sb_push("t5_rel8", 8, 8'hFF, 8'h00, 8'hFF, 8'h00, 1, 1'b0, 3'd0);
        tick(10);
        bus.ir_in = 8'h00;
        tick(3);
        bus.ir_in = 8'h02;
        sb_push("t5_post", 3, 8'hFF, 8'h02, 8'hFF, 8'h00, 0, 1'b0, 3'd0);
        tick(1); bus.ir_in = 8'h00; tick(5);

        for (int i = 0; i < 20 && sb_q.size() > 0; i++) tick(1);
        while (sb_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL %s: expectation never sampled (due cycle %0d)", sb_q[0].name, sb_q[0].cyc);
            sb_q.delete(0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/irr_param.md
IRR_PARAM -- requirements
Module: irr_param

Interface
REQ-001 Parameter N, default 8: number of interrupt channels, 2..32.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser flops per channel, 1..4.
REQ-003 Parameter IW = $clog2(N): channel-index width, derived, not overridable.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 ir_in  in  N  raw asynchronous interrupt request lines.
REQ-007 ltim  in  N  per-channel trigger mode: 1 = level, 0 = rising edge.
REQ-008 imr  in  N  per-channel mask: 1 = masked from arbitration.
REQ-009 pri_base  in  IW  channel that holds highest priority; priority falls with ascending index, modulo N.
REQ-010 ack_valid  in  1  single-cycle acknowledge strobe.
REQ-011 ack_id  in  IW  channel being acknowledged.
REQ-012 lost_clr  in  1  single-cycle strobe that clears all lost flags.
REQ-013 irr  out  N  registered interrupt request register.
REQ-014 int_req  out  1  registered: at least one unmasked irr bit is set.
REQ-015 int_id  out  IW  registered: highest-priority unmasked pending channel.
REQ-016 lost  out  N  sticky flags: an edge arrived while the irr bit was already set.

Function
REQ-017 Each ir_in bit SHALL pass through SYNC_STAGES flops; s[i] is the last stage. p[i] is a further flop of s[i], used for edge detection.
REQ-018 Edge channels (ltim[i]=0): irr[i] SHALL be set on the clock where s[i]=1 and p[i]=0. Latency is SYNC_STAGES+1 clocks from the first clock edge that samples ir_in[i] high.
REQ-019 Edge channels SHALL hold irr[i] until a matching acknowledge, regardless of ir_in falling.
REQ-020 Level channels (ltim[i]=1): irr[i] SHALL equal s[i], registered one clock later. The acknowledge clears it for one clock only; it re-asserts if s[i] is still 1.
REQ-021 Acknowledge: ack_valid=1 SHALL clear irr[ack_id] on that clock. ack_id >= N is ignored.
REQ-022 If a new edge and an acknowledge hit the same channel on the same clock, the set SHALL win: irr stays 1 and lost is not set.
REQ-023 An edge on a channel whose irr bit is already 1, with no same-clock acknowledge, SHALL set lost[i].
REQ-024 lost_clr SHALL clear all lost bits. A lost event on the same clock SHALL win for its bit.
REQ-025 Changing ltim[i] from 1 to 0 SHALL NOT generate an edge; p[i] continues to track s[i].
REQ-026 Arbitration: search irr & ~imr starting at pri_base, ascending and wrapping N-1 to 0. The first set bit SHALL be registered into int_id, one clock after irr.
REQ-027 int_req SHALL be registered together with int_id. When int_req=0, int_id SHALL be 0.
REQ-028 imr and pri_base changes SHALL affect int_req/int_id on the next clock only and SHALL never modify irr.
REQ-029 Only the masked view depends on imr; masked requests SHALL still set irr and lost.

Reset
REQ-030 While reset=1 on a clock edge, all synchroniser flops, p, irr and lost SHALL clear to 0, int_req SHALL be 0 and int_id SHALL be 0.
REQ-031 Reset SHALL override ack_valid, lost_clr and edges on the same clock.
REQ-032 An ir_in line held high through the release of reset SHALL NOT produce an edge. p is loaded from s during the synchroniser refill, so the flop chain refills silently.
REQ-033 A level channel held high through reset SHALL set irr SYNC_STAGES+1 clocks after reset deasserts.

Verification (N=8, SYNC_STAGES=2)
REQ-034 All channels are edge mode, imr=0, pri_base=0. Raise ir_in=8'h08 at clock k. Required: irr=8'h08 after clock k+3, int_req=1 and int_id=3 after k+4. Drop ir_in: irr stays 8'h08. Pulse ack_id=3: irr=0, and int_req=0 two clocks later.
REQ-035 Edge mode. Two separate pulses on ir_in[5] with no acknowledge in between. Required: irr[5]=1 and lost=8'h20. Pulse lost_clr: lost=0, and irr[5] stays 1.
REQ-036 Level mode on channel 2 with ir_in[2] held high. Pulse ack_id=2. Required: irr[2]=0 for exactly one clock, then 1 again. Release ir_in[2]: irr[2]=0 three clocks later.
REQ-037 irr=8'h81, imr=0. pri_base=0 gives int_id=0; pri_base=1 gives int_id=7. Then set imr=8'h80: int_id=0.
REQ-038 Same-clock edge and acknowledge on channel 4 (edge mode, irr[4] already set): irr[4] stays 1 and lost[4] stays 0. Reset asserted while ir_in=8'hFF: all outputs are 0, and no edge is captured after release.
